// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined barrel shifter (LSL/LSR/ASR/ROR) with carry-out and valid/ready
//
// One shift-amount bit is resolved per register stage (stage k shifts by 2^k),
// giving SHW = $clog2(WIDTH) stages and a latency of SHW cycles per op.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    input handshake; in_ready is the pipeline advance enable
//   in_data, in_amount   operand and shift amount (0..WIDTH-1)
//   in_type              00 LSL, 01 LSR, 10 ASR, 11 ROR
//   in_carry             carry flag, passed through when amount is 0
//   out_valid/out_ready  output handshake
//   out_data, out_carry  shifted result and last bit shifted/rotated out
//   busy                 registered OR of all stage valids
module shift_pipe #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amount,
  input  logic [1:0]       in_type,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             busy
);

  // All stages move in lockstep; bubbles are kept so timing stays fixed.
  logic           adv;
  logic [SHW-1:0] v_next;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < SHW; k++) begin : stage
    // Remaining amount bits (k..SHW-1) carried into this stage; bit 0 of ai is amount bit k.
    localparam int R = SHW - k;
    localparam int S = 1 << k;

    logic             vi;
    logic [WIDTH-1:0] di;
    logic             ci;
    logic [R-1:0]     ai;
    logic [1:0]       ti;

    logic [WIDTH-1:0] dn;
    logic             cn;

    logic             v_q;
    logic [WIDTH-1:0] d_q;
    logic             c_q;

    if (k == 0) begin : src
      assign vi = in_valid;
      assign di = in_data;
      assign ci = in_carry;
      assign ai = in_amount;
      assign ti = in_type;
    end else begin : src
      assign vi = stage[k-1].v_q;
      assign di = stage[k-1].d_q;
      assign ci = stage[k-1].c_q;
      assign ai = stage[k-1].hold.amt_q;
      assign ti = stage[k-1].hold.type_q;
    end

    always_comb begin
      dn = di;
      cn = ci;
      if (ai[0]) begin
        case (ti)
          2'b00: begin
            dn = di << S;
            cn = di[WIDTH-S];
          end
          2'b01: begin
            dn = di >> S;
            cn = di[S-1];
          end
          2'b10: begin
            dn = $signed(di) >>> S;
            cn = di[S-1];
          end
          default: begin
            // The bit rotated into the MSB is the carry-out.
            dn = {di[S-1:0], di[WIDTH-1:S]};
            cn = di[S-1];
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        v_q <= vi;
        d_q <= dn;
        c_q <= cn;
      end
    end

    assign v_next[k] = adv ? vi : v_q;

    // Amount and type are only needed by later stages; the final stage drops them.
    if (k < SHW - 1) begin : hold
      logic [R-2:0] amt_q;
      logic [1:0]   type_q;

      always_ff @(posedge clk) begin
        if (adv) begin
          amt_q  <= ai[R-1:1];
          type_q <= ti;
        end
      end
    end
  end

  assign out_valid = stage[SHW-1].v_q;
  assign out_data  = stage[SHW-1].d_q;
  assign out_carry = stage[SHW-1].c_q;

  // Registered from the next-state valids so it tracks the stage valids exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= |v_next;
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - directed self-checking bench for shift_pipe (WIDTH = 32)
module tb_shift_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amount;
  logic [1:0]  in_type;
  logic        in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_carry;
  logic        busy;

  int errors = 0;
  int checks = 0;

  shift_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_type   (in_type),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11;

  // Drives one op with out_ready high and waits (bounded) for its result.
  // lat counts clock edges from the accepting edge (inclusive) to out_valid.
  task automatic run_op(input logic [31:0] d, input logic [4:0] a, input logic [1:0] t,
                        input logic c, output logic [31:0] rd, output logic rc, output int lat);
    in_data   = d;
    in_amount = a;
    in_type   = t;
    in_carry  = c;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = out_data;
    rc = out_carry;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amount = '0;
    in_type   = '0;
    in_carry  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
    checks++;
    if (out_carry !== 1'b0) begin errors++; $display("FAIL reset_out_carry got %b want 0", out_carry); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_lsl();
    logic [31:0] rd;
    logic        rc;
    int          lat;
    run_op(32'h0000_0001, 5'd31, LSL, 1'b0, rd, rc, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL lsl31_latency got %0d want 5", lat); end
    checks++;
    if (rd !== 32'h8000_0000) begin errors++; $display("FAIL lsl31_data got %h want 80000000", rd); end
    checks++;
    if (rc !== 1'b0) begin errors++; $display("FAIL lsl31_carry got %b want 0", rc); end
    run_op(32'hC000_0000, 5'd1, LSL, 1'b0, rd, rc, lat);
    checks++;
    if (rd !== 32'h8000_0000 || rc !== 1'b1) begin
      errors++; $display("FAIL lsl1 got %h/%b want 80000000/1", rd, rc);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL lsl_drained got valid %b busy %b want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_lsr_asr();
    logic [31:0] rd;
    logic        rc;
    int          lat;
    run_op(32'h8000_0001, 5'd1, LSR, 1'b0, rd, rc, lat);
    checks++;
    if (rd !== 32'h4000_0000 || rc !== 1'b1) begin
      errors++; $display("FAIL lsr1 got %h/%b want 40000000/1", rd, rc);
    end
    run_op(32'h8000_0000, 5'd4, ASR, 1'b1, rd, rc, lat);
    checks++;
    if (rd !== 32'hF800_0000 || rc !== 1'b0) begin
      errors++; $display("FAIL asr4 got %h/%b want f8000000/0", rd, rc);
    end
    run_op(32'h7FFF_FFFF, 5'd31, ASR, 1'b0, rd, rc, lat);
    checks++;
    if (rd !== 32'h0000_0000 || rc !== 1'b1) begin
      errors++; $display("FAIL asr31_pos got %h/%b want 00000000/1", rd, rc);
    end
    run_op(32'h0000_000F, 5'd4, LSR, 1'b0, rd, rc, lat);
    checks++;
    if (rd !== 32'h0000_0000 || rc !== 1'b1) begin
      errors++; $display("FAIL lsr4 got %h/%b want 00000000/1", rd, rc);
    end
  endtask

  task automatic test_ror();
    logic [31:0] rd;
    logic        rc;
    int          lat;
    run_op(32'h0000_0001, 5'd1, ROR, 1'b0, rd, rc, lat);
    checks++;
    if (rd !== 32'h8000_0000 || rc !== 1'b1) begin
      errors++; $display("FAIL ror1 got %h/%b want 80000000/1", rd, rc);
    end
    run_op(32'h1234_5678, 5'd8, ROR, 1'b1, rd, rc, lat);
    checks++;
    if (rd !== 32'h7812_3456 || rc !== 1'b0) begin
      errors++; $display("FAIL ror8 got %h/%b want 78123456/0", rd, rc);
    end
    run_op(32'h8000_0000, 5'd31, ROR, 1'b1, rd, rc, lat);
    checks++;
    if (rd !== 32'h0000_0001 || rc !== 1'b0) begin
      errors++; $display("FAIL ror31 got %h/%b want 00000001/0", rd, rc);
    end
  endtask

  task automatic test_amount_zero();
    logic [31:0] rd;
    logic        rc;
    int          lat;
    for (int t = 0; t < 4; t++) begin
      run_op(32'hDEAD_BEEF, 5'd0, t[1:0], 1'b1, rd, rc, lat);
      checks++;
      if (rd !== 32'hDEAD_BEEF || rc !== 1'b1) begin
        errors++; $display("FAIL amt0_type%0d got %h/%b want deadbeef/1", t, rd, rc);
      end
    end
    run_op(32'h0000_0001, 5'd0, LSL, 1'b0, rd, rc, lat);
    checks++;
    if (rd !== 32'h0000_0001 || rc !== 1'b0) begin
      errors++; $display("FAIL amt0_carry0 got %h/%b want 00000001/0", rd, rc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] td [8] = '{32'h0000_0003, 32'h0000_0003, 32'h8000_0018, 32'h0000_00F0,
                            32'h0000_000F, 32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [4:0]  ta [8] = '{5'd1, 5'd1, 5'd4, 5'd4, 5'd4, 5'd0, 5'd16, 5'd16};
    logic [1:0]  tt [8] = '{LSL, LSR, ASR, ROR, ROR, LSL, LSL, LSR};
    logic        tc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ed [8] = '{32'h0000_0006, 32'h0000_0001, 32'hF800_0001, 32'h0000_000F,
                            32'hF000_0000, 32'h0000_0001, 32'hFFFF_0000, 32'h0000_1234};
    logic        ec [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int          snd = 0;
    int          rcv = 0;
    int          stalls = 0;
    logic        held_ok = 1'b0;
    logic [31:0] held_d = '0;
    logic        held_c = 1'b0;
    logic        stall;
    logic        acc;
    logic        cons;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      in_valid  = (snd < 8);
      in_data   = td[snd % 8];
      in_amount = ta[snd % 8];
      in_type   = tt[snd % 8];
      in_carry  = tc[snd % 8];
      out_ready = !(cyc >= 6 && cyc <= 8);
      #1;
      stall = out_valid && !out_ready;
      checks++;
      if (in_ready !== !stall) begin
        errors++; $display("FAIL b2b_in_ready cyc %0d got %b want %b", cyc, in_ready, !stall);
      end
      if (stall && held_ok) begin
        checks++;
        if (out_data !== held_d || out_carry !== held_c) begin
          errors++; $display("FAIL b2b_hold cyc %0d got %h/%b want %h/%b", cyc, out_data, out_carry, held_d, held_c);
        end
      end
      if (stall) stalls++;
      held_ok = stall;
      held_d  = out_data;
      held_c  = out_carry;
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        checks++;
        if (rcv >= 8 || out_data !== ed[rcv % 8] || out_carry !== ec[rcv % 8]) begin
          errors++; $display("FAIL b2b_result %0d got %h/%b want %h/%b", rcv, out_data, out_carry, ed[rcv % 8], ec[rcv % 8]);
        end
        rcv++;
      end
      if (acc) snd++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (rcv !== 8 || snd !== 8) begin errors++; $display("FAIL b2b_count got rcv %0d snd %0d want 8/8", rcv, snd); end
    checks++;
    if (stalls !== 3) begin errors++; $display("FAIL b2b_stall_cycles got %0d want 3", stalls); end
    repeat (8) begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_result got valid %b want 0", out_valid); end
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_idle got %b want 0", busy); end
  endtask

  task automatic test_reset_in_flight();
    logic [31:0] rd;
    logic        rc;
    int          lat;
    logic        seen = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_data   = 32'h0000_0100 << i;
      in_amount = 5'd2;
      in_type   = LSL;
      in_carry  = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rif_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rif_after_reset got valid %b busy %b want 0/0", out_valid, busy);
    end
    repeat (10) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rif_stale_result got %b want 0", seen); end
    run_op(32'h0000_00F0, 5'd4, LSR, 1'b1, rd, rc, lat);
    checks++;
    if (lat !== 5 || rd !== 32'h0000_000F || rc !== 1'b0) begin
      errors++; $display("FAIL rif_recover got lat %0d %h/%b want 5 0000000f/0", lat, rd, rc);
    end
  endtask

  initial begin
    test_reset();
    test_lsl();
    test_lsr_asr();
    test_ror();
    test_amount_zero();
    test_back_to_back();
    test_reset_in_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
